// File: rtl/combine_sequencer.sv
// combine_sequencer: 24-game slot datapath, combines two slots per request.
// Define COMBINE_UNDO_EN to add a one-deep undo snapshot of slots and valid.
module combine_sequencer #(
  parameter int WIDTH  = 10,
  parameter int TARGET = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] m1,
  input  logic [WIDTH-1:0] m2,
  input  logic [WIDTH-1:0] m3,
  input  logic [WIDTH-1:0] m4,
  input  logic             op_req,
  input  logic [1:0]       sel_a,
  input  logic [1:0]       sel_b,
  input  logic [1:0]       op,
  input  logic             undo,
  output logic [WIDTH-1:0] num1,
  output logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] num3,
  output logic [WIDTH-1:0] num4,
  output logic [3:0]       valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             win,
  output logic             lose
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DIV,
    S_WRITE
  } state_e;

  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_SAME = 3'd1;
  localparam logic [2:0] E_DEAD = 3'd2;
  localparam logic [2:0] E_NEG  = 3'd3;
  localparam logic [2:0] E_OVF  = 3'd4;
  localparam logic [2:0] E_DIV0 = 3'd5;
  localparam logic [2:0] E_INEX = 3'd6;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TGT  = WIDTH'(TARGET);

  state_e state_q, state_d;

  logic [WIDTH-1:0] slot_q [4];
  logic [WIDTH-1:0] slot_d [4];
  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       sa_q, sa_d;
  logic [1:0]       sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;

  logic               accept;
  logic               undo_go;
  logic [2:0]         chk_code;
  logic [WIDTH-1:0]   alu_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic               div_last;
  logic               div_inexact;
  logic [3:0]         wr_valid;
  logic               wr_single;

`ifdef COMBINE_UNDO_EN
  logic [WIDTH-1:0] bak_slot_q [4];
  logic [3:0]       bak_valid_q;
  logic             bak_ok_q;

  assign undo_go = undo && !load && (state_q == S_IDLE) && bak_ok_q;

  // Snapshot the board just before each write-back; load or undo drop it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) bak_slot_q[i] <= '0;
      bak_valid_q <= '0;
      bak_ok_q    <= 1'b0;
    end else if (load || undo_go) begin
      bak_ok_q <= 1'b0;
    end else if (state_q == S_WRITE) begin
      bak_slot_q  <= slot_q;
      bak_valid_q <= valid_q;
      bak_ok_q    <= 1'b1;
    end
  end
`else
  logic unused_undo;
  assign unused_undo = undo;
  assign undo_go     = 1'b0;
`endif

  assign accept = op_req && !load && !undo_go &&
                  (state_q == S_IDLE) && !win_q && !lose_q;

  assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Restoring divider step: shift in next dividend bit, subtract if it fits.
  assign rem_sh      = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff    = rem_sh - {1'b0, b_q};
  assign qbit        = ~rem_diff[WIDTH];
  assign rem_nx      = qbit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx      = {quo_q[WIDTH-2:0], qbit};
  assign div_last    = (cnt_q == LAST);
  assign div_inexact = (rem_nx != '0);

  assign wr_valid  = valid_q & ~(4'b0001 << sb_q);
  assign wr_single = ($countones(wr_valid) == 1);

  // Operand legality checks, evaluated in priority order during EXEC.
  always_comb begin
    chk_code = E_NONE;
    if (sa_q == sb_q) begin
      chk_code = E_SAME;
    end else if (!valid_q[sa_q] || !valid_q[sb_q]) begin
      chk_code = E_DEAD;
    end else begin
      unique case (1'b1)
        (op_q == OP_SUB): if (a_q < b_q) chk_code = E_NEG;
        (op_q == OP_MUL): if (|prod[2*WIDTH-1:WIDTH]) chk_code = E_OVF;
        (op_q == OP_DIV): if (b_q == '0) chk_code = E_DIV0;
        default:          chk_code = E_NONE;
      endcase
    end
  end

  // Single-cycle add/sub/mul result.
  always_comb begin
    alu_res = a_q + b_q;
    unique case (1'b1)
      (op_q == OP_SUB): alu_res = a_q - b_q;
      (op_q == OP_MUL): alu_res = prod[WIDTH-1:0];
      default:          alu_res = a_q + b_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; load aborts whatever is in flight.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (accept) state_d = S_EXEC;
        S_EXEC: begin
          if (chk_code != E_NONE) state_d = S_IDLE;
          else if (op_q == OP_DIV) state_d = S_DIV;
          else                     state_d = S_WRITE;
        end
        S_DIV: begin
          if (div_last) state_d = div_inexact ? S_IDLE : S_WRITE;
        end
        S_WRITE: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next-state: slots, operands, divider, status flags.
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    win_d   = win_q;
    lose_d  = lose_q;
    if (load) begin
      slot_d[0] = m1;
      slot_d[1] = m2;
      slot_d[2] = m3;
      slot_d[3] = m4;
      valid_d   = 4'b1111;
      win_d     = 1'b0;
      lose_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
`ifdef COMBINE_UNDO_EN
          if (undo_go) begin
            slot_d  = bak_slot_q;
            valid_d = bak_valid_q;
            win_d   = 1'b0;
            lose_d  = 1'b0;
            done_d  = 1'b1;
          end else
`endif
          if (accept) begin
            a_d  = slot_q[sel_a];
            b_d  = slot_q[sel_b];
            op_d = op;
            sa_d = sel_a;
            sb_d = sel_b;
          end
        end
        S_EXEC: begin
          if (chk_code != E_NONE) begin
            err_d  = 1'b1;
            code_d = chk_code;
          end else begin
            res_d = alu_res;
            rem_d = '0;
            quo_d = a_q;
            cnt_d = '0;
          end
        end
        S_DIV: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CW'(1);
          if (div_last) begin
            if (div_inexact) begin
              err_d  = 1'b1;
              code_d = E_INEX;
            end else begin
              res_d = quo_nx;
            end
          end
        end
        S_WRITE: begin
          slot_d[sa_q] = res_q;
          valid_d      = wr_valid;
          done_d       = 1'b1;
          if (wr_single) begin
            if (res_q == TGT) win_d = 1'b1;
            else              lose_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  // Output decode.
  always_comb begin
    busy     = (state_q != S_IDLE);
    num1     = slot_q[0];
    num2     = slot_q[1];
    num3     = slot_q[2];
    num4     = slot_q[3];
    valid    = valid_q;
    done     = done_q;
    err      = err_q;
    err_code = code_q;
    win      = win_q;
    lose     = lose_q;
  end

endmodule

// File: doc/combine_sequencer.md
Name: combine_sequencer

Overview:
- Arithmetic sequencer for the 24-game datapath. Holds the four puzzle slot values and their valid mask.
- Accepts "combine slot A with slot B using operator" requests from the game FSM.
- Runs the operation: single-cycle add/sub/mul, multi-cycle iterative divide. Writes the result into slot A, retires slot B, and flags win/lose when one slot remains.
- Sits between the game FSM (requester) and number_converter/vga (consumers of slot values and valid mask).

Parameters:
- WIDTH, 10, bit width of each slot value (unsigned integer).
- TARGET, 24, winning value of the final remaining slot.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- load  input  1  single-cycle pulse: latch m1..m4 into slots, set valid=4'b1111
- m1, m2, m3, m4  input  WIDTH each  new puzzle values
- op_req  input  1  single-cycle pulse: request combine
- sel_a  input  2  destination/left operand slot index
- sel_b  input  2  right operand slot index (retired on success)
- op  input  2  00 add, 01 sub (a-b), 10 mul, 11 div (a/b)
- undo  input  1  single-cycle pulse (see Optional Feature)
- num1, num2, num3, num4  output  WIDTH each  slot values
- valid  output  4  slot-live mask, bit i = slot i
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse on successful write-back
- err  output  1  one-cycle pulse on rejected operation
- err_code  output  3  1 same slot, 2 dead slot, 3 negative, 4 overflow, 5 div by zero, 6 inexact; holds until next err
- win  output  1  sticky
- lose  output  1  sticky

Behaviour:
- Reset (rst=0, async): slots=0, valid=0, busy=0, done=0, err=0, err_code=0, win=0, lose=0, state IDLE.
- States: IDLE, EXEC, DIV, WRITE.
- IDLE:
  - op_req with busy=0: register operands, op and selects at edge E0; busy=1; go EXEC.
  - op_req while busy=1 is ignored silently.
- EXEC (one cycle):
  - Check sel_a==sel_b -> code 1.
  - Check either slot invalid -> code 2.
  - Sub with a<b -> code 3.
  - Mul full product > 2^WIDTH-1 -> code 4.
  - Div with b==0 -> code 5.
  - Any error: err pulse and err_code after E1; slots and valid unchanged; return IDLE, busy=0.
  - Add/sub/mul OK: go WRITE.
  - Div OK: go DIV.
- DIV: restoring divider, one quotient bit per cycle, exactly WIDTH cycles. Nonzero remainder -> code 6 (err after the last iteration edge), no write, IDLE. Else go WRITE.
- WRITE:
  - slot[sel_a]=result; valid[sel_b]=0; done pulse; busy=0.
  - Latency op_req to done: 2 edges for add/sub/mul; WIDTH+2 edges for div.
- End of game: after WRITE, if popcount(valid)==1, the surviving slot value == TARGET sets win, else sets lose.
- Once win or lose is set, op_req is ignored until load.
- load: highest priority in any state.
  - Aborts any in-flight op: no done, no err.
  - Clears win/lose; busy=0; IDLE next cycle.
- load and op_req same cycle: load wins, op_req dropped.
- Retired slots keep their last value; consumers must gate on valid.

Optional Feature:
- Macro: COMBINE_UNDO_EN.
- Defined:
  - Each WRITE first snapshots slots+valid into a one-deep backup and sets backup_ok.
  - undo in IDLE with backup_ok=1 restores the snapshot, clears win/lose and backup_ok, and pulses done.
  - undo while busy, or with backup_ok=0, is ignored.
  - load and reset clear backup_ok.
- Not defined: no backup registers; undo input unconnected internally and has no effect.

Test Plan:
- Load 1,2,3,4; mul(0,1) -> slot0=2, valid=1101; mul(0,2) -> 6, valid=1001; mul(0,3) -> 24, valid=0001, win=1, done 2 edges after each req.
- Load 12,4,1,1; div(0,1) -> busy for 12 edges, slot0=3, valid=1101; then load 7,2,1,1; div(0,1) -> err code 6, slots unchanged.
- Load 5,5,4,1; sub(0,1) -> slot0=0; div(2,0) -> err code 5; sub(3,2) (1-4) -> err code 3.
- Load 13,13,13,1; mul(0,1) -> 169; mul(0,2) -> err code 4; op_req(1,1) -> code 1; op_req using retired slot 1 -> code 2.
- Start div, assert load at 4th DIV cycle -> no done/err, new values loaded, valid=1111; rst low mid-op -> all outputs zero immediately.
- With COMBINE_UNDO_EN: load 1,2,3,4; add(0,1) -> 3, valid=1101; undo -> slots 1,2,3,4, valid=1111; second undo ignored.
